// File: rtl/burst_arbiter.sv
// Round-robin arbiter that hands the shared burst queue/serializer path to one bank requester for BL/2 cycles.
// Define BURST_ARB_TAT_EN to build the TURN state and insert TAT idle cycles on read/write direction changes.
module burst_arbiter #(
    parameter int NREQ = 4,
    parameter int BL   = 8,
    parameter int TAT  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         req_wr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] gnt_id_o,
    output logic                    q_valid_o,
    output logic                    busy_o,
    output logic                    burst_last_o
);

    localparam int IW    = $clog2(NREQ);
    localparam int BEATS = BL / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1
`ifdef BURST_ARB_TAT_EN
        ,TURN = 2'd2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;

`ifdef BURST_ARB_TAT_EN
    localparam int TW = (TAT > 1) ? $clog2(TAT) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TAT - 1);

    logic          win_dir_q, win_dir_d;
    logic          last_dir_q, last_dir_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ref_dir;
`else
    logic          unused_cfg;

    assign unused_cfg = (^req_wr_i) ^ (TAT > 0);
`endif

    logic          found;
    logic [IW-1:0] pick;
    logic [IW:0]   cand;
    logic          launch;

    // Round-robin search starting one past the last winner, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i + 1);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    // A new winner is taken from IDLE or on the final beat of a burst, so bursts chain without a gap.
    assign launch = found && ((state_q == IDLE) ||
                              ((state_q == BURST) && (cnt_q == CNT_LAST)));

`ifdef BURST_ARB_TAT_EN
    // At a burst boundary the outgoing burst's direction is the one that counts.
    assign ref_dir = (state_q == BURST) ? win_dir_q : last_dir_q;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
`ifdef BURST_ARB_TAT_EN
        win_dir_d  = win_dir_q;
        last_dir_d = last_dir_q;
        tcnt_d     = tcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
            end
            BURST: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef BURST_ARB_TAT_EN
                    last_dir_d = win_dir_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef BURST_ARB_TAT_EN
            TURN: begin
                if (tcnt_q == TCNT_LAST) begin
                    state_d = BURST;
                    ptr_d   = win_q;
                    cnt_d   = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            win_d   = pick;
            cnt_d   = '0;
            state_d = BURST;
            ptr_d   = pick;
`ifdef BURST_ARB_TAT_EN
            win_dir_d = req_wr_i[pick];
            // The winner is committed now; ptr moves only once its grant actually starts.
            if (req_wr_i[pick] != ref_dir) begin
                state_d = TURN;
                ptr_d   = ptr_q;
                tcnt_d  = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
`ifdef BURST_ARB_TAT_EN
            win_dir_q  <= 1'b0;
            last_dir_q <= 1'b0;
            tcnt_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
`ifdef BURST_ARB_TAT_EN
            win_dir_q  <= win_dir_d;
            last_dir_q <= last_dir_d;
            tcnt_q     <= tcnt_d;
`endif
        end
    end

    always_comb begin
        gnt_o        = '0;
        gnt_o[win_q] = (state_q == BURST);
    end

    assign gnt_id_o     = win_q;
    assign busy_o       = (state_q != IDLE);
    assign q_valid_o    = (state_q == BURST) && (cnt_q == '0);
    assign burst_last_o = (state_q == BURST) && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_burst_arbiter.sv
// Self-checking bench for burst_arbiter: directed scenarios plus randomized traffic against a burst-schedule model.
// Honours BURST_ARB_TAT_EN so the expected turnaround gap follows the build.
module tb_burst_arbiter;

    localparam int NREQ = 4;
    localparam int BL   = 8;
    localparam int TAT  = 2;
`ifdef BURST_ARB_TAT_EN
    localparam bit TatEn = 1'b1;
`else
    localparam bit TatEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] reqWr = '0;
    logic [3:0] gnt;
    logic [1:0] gntId;
    logic       qValid, busy, burstLast;

    logic [3:0] req2 = '0;
    logic [3:0] reqWr2 = '0;
    logic [3:0] gnt2;
    logic [1:0] gntId2;
    logic       qValid2, busy2, burstLast2;

    int checks = 0;
    int fails  = 0;

    // Expected outputs of one clock cycle, queued ahead as each burst is scheduled.
    typedef struct {
        logic [3:0] gnt;
        logic       qv;
        logic       bl;
        logic       busy;
        logic [1:0] id;
        logic       turn;
    } expCycle_t;

    expCycle_t expQ[$];
    int        mPtr     = NREQ - 1;
    bit        mLastDir = 1'b0;
    int        mLastId  = 0;

    burst_arbiter #(.NREQ(NREQ), .BL(BL), .TAT(TAT)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_wr_i(reqWr),
        .gnt_o(gnt), .gnt_id_o(gntId), .q_valid_o(qValid),
        .busy_o(busy), .burst_last_o(burstLast)
    );

    burst_arbiter #(.NREQ(NREQ), .BL(2), .TAT(TAT)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .req_wr_i(reqWr2),
        .gnt_o(gnt2), .gnt_id_o(gntId2), .q_valid_o(qValid2),
        .busy_o(busy2), .burst_last_o(burstLast2)
    );

    always #5 clk = ~clk;

    // Whenever the schedule runs dry, pick the next round-robin winner and lay out its gap and beats.
    task automatic modelEdge();
        if (rst) begin
            expQ.delete();
            mPtr     = NREQ - 1;
            mLastDir = 1'b0;
            mLastId  = 0;
        end else begin
            if (expQ.size() > 0) void'(expQ.pop_front());
            if (expQ.size() == 0) begin
                int w;
                expCycle_t e;
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (mPtr + k) % NREQ;
                    if (w < 0 && req[c]) w = c;
                end
                if (w >= 0) begin
                    if (TatEn && (reqWr[w] != mLastDir)) begin
                        for (int t = 0; t < TAT; t++) begin
                            e.gnt = '0; e.qv = 1'b0; e.bl = 1'b0; e.busy = 1'b1;
                            e.id = 2'(w); e.turn = 1'b1;
                            expQ.push_back(e);
                        end
                    end
                    for (int b = 0; b < BL/2; b++) begin
                        e.gnt = 4'b0001 << w; e.qv = (b == 0); e.bl = (b == BL/2 - 1);
                        e.busy = 1'b1; e.id = 2'(w); e.turn = 1'b0;
                        expQ.push_back(e);
                    end
                    mPtr     = w;
                    mLastDir = reqWr[w];
                    mLastId  = w;
                end
            end
        end
    endtask

    function automatic expCycle_t expNow();
        expCycle_t e;
        if (expQ.size() > 0) begin
            e = expQ[0];
        end else begin
            e.gnt = '0; e.qv = 1'b0; e.bl = 1'b0; e.busy = 1'b0;
            e.id = 2'(mLastId); e.turn = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst = 1'b1; req = '0; reqWr = '0; req2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; reqWr = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || qValid !== 1'b0 || burstLast !== 1'b0 || gntId !== 2'd0) begin
                fails++;
                $display("[TB] FAIL reset_outputs: gnt=%b busy=%b qValid=%b burstLast=%b gntId=%0d, expected all 0",
                         gnt, busy, qValid, burstLast, gntId);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] eg;
            eg = 4'b0001 << ((k / 4) % 4);
            @(negedge clk);
            checks++;
            if (gnt !== eg || gntId !== 2'((k / 4) % 4)) begin
                fails++;
                $display("[TB] FAIL rr_order cycle %0d: gnt=%b id=%0d, expected gnt=%b id=%0d", k, gnt, gntId, eg, (k / 4) % 4);
            end
            checks++;
            if (qValid !== (k % 4 == 0) || burstLast !== (k % 4 == 3) || busy !== 1'b1) begin
                fails++;
                $display("[TB] FAIL rr_pulses cycle %0d: qValid=%b burstLast=%b busy=%b, expected %b %b 1",
                         k, qValid, burstLast, busy, k % 4 == 0, k % 4 == 3);
            end
            if (k == 19) req = 4'b0000;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || gntId !== 2'd0) begin
            fails++;
            $display("[TB] FAIL rr_idle: busy=%b gnt=%b id=%0d, expected 0 0000 0", busy, gnt, gntId);
        end
    endtask

    task automatic test_single();
        req = 4'b0100; reqWr = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || qValid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_latency: gnt=%b qValid=%b busy=%b, expected 0100 1 1", gnt, qValid, busy);
        end
        req = 4'b0000;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0100 || qValid !== 1'b0 || burstLast !== (k == 3)) begin
                fails++;
                $display("[TB] FAIL single_burst cycle %0d: gnt=%b qValid=%b burstLast=%b, expected 0100 0 %b",
                         k, gnt, qValid, burstLast, k == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || gntId !== 2'd2) begin
            fails++;
            $display("[TB] FAIL single_idle: busy=%b gnt=%b id=%0d, expected 0 0000 2", busy, gnt, gntId);
        end
    endtask

    task automatic test_turnaround();
        int gap;
        bit seen;
        applyReset();
        req = 4'b0011; reqWr = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || qValid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL tat_first: gnt=%b qValid=%b, expected 0001 1", gnt, qValid);
        end
        req = 4'b0010;
        repeat (3) @(negedge clk);
        checks++;
        if (burstLast !== 1'b1 || gnt !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL tat_read_last: burstLast=%b gnt=%b, expected 1 0001", burstLast, gnt);
        end
        gap = 0; seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (qValid === 1'b1) begin
                seen = 1'b1;
            end else begin
                gap++;
                checks++;
                if (gnt !== 4'b0000 || busy !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL tat_gap_cycle %0d: gnt=%b busy=%b, expected 0000 1", k, gnt, busy);
                end
            end
        end
        checks++;
        if (!seen || gap != (TatEn ? TAT : 0)) begin
            fails++;
            $display("[TB] FAIL tat_gap_len: seen=%0d gap=%0d, expected seen=1 gap=%0d", seen, gap, TatEn ? TAT : 0);
        end
        checks++;
        if (gnt !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL tat_write_gnt: gnt=%b, expected 0010", gnt);
        end
        req = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_drop();
        applyReset();
        req = 4'b0010; reqWr = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0010 || qValid !== (k == 1) || burstLast !== (k == 4)) begin
                fails++;
                $display("[TB] FAIL drop_burst cycle %0d: gnt=%b qValid=%b burstLast=%b, expected 0010 %b %b",
                         k, gnt, qValid, burstLast, k == 1, k == 4);
            end
            if (k == 2) req = 4'b1000;
        end
        for (int k = 5; k <= 11; k++) begin
            logic [3:0] eg;
            eg = (k <= 8) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            checks++;
            if (gnt !== eg || busy !== (k <= 8)) begin
                fails++;
                $display("[TB] FAIL drop_after cycle %0d: gnt=%b busy=%b, expected %b %b", k, gnt, busy, eg, k <= 8);
            end
            if (k == 5) req = 4'b0000;
        end
    endtask

    task automatic test_bl2();
        applyReset();
        req2 = 4'b0011; reqWr2 = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] eg;
            eg = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            @(negedge clk);
            checks++;
            if (gnt2 !== eg || gntId2 !== 2'(k % 2)) begin
                fails++;
                $display("[TB] FAIL bl2_gnt cycle %0d: gnt=%b id=%0d, expected %b %0d", k, gnt2, gntId2, eg, k % 2);
            end
            checks++;
            if (qValid2 !== 1'b1 || burstLast2 !== 1'b1 || busy2 !== 1'b1) begin
                fails++;
                $display("[TB] FAIL bl2_pulses cycle %0d: qValid=%b burstLast=%b busy=%b, expected 1 1 1",
                         k, qValid2, burstLast2, busy2);
            end
        end
        req2 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b0 || gnt2 !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL bl2_idle: busy=%b gnt=%b, expected 0 0000", busy2, gnt2);
        end
    endtask

    task automatic test_reset_mid();
        applyReset();
        req = 4'b0100; reqWr = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || qValid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rstmid_pre: gnt=%b qValid=%b, expected 0100 0", gnt, qValid);
        end
        rst = 1'b1; req = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || qValid !== 1'b0 || burstLast !== 1'b0 || gntId !== 2'd0) begin
            fails++;
            $display("[TB] FAIL rstmid_zero: gnt=%b busy=%b qValid=%b burstLast=%b id=%0d, expected all 0",
                     gnt, busy, qValid, burstLast, gntId);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || qValid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rstmid_ptr: gnt=%b qValid=%b, expected 0001 1", gnt, qValid);
        end
        req = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        expCycle_t e;
        rst = 1'b1; req = '0; reqWr = '0; req2 = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            e = expNow();
            checks++;
            if (gnt !== e.gnt) begin
                fails++;
                $display("[TB] FAIL rand_gnt cycle %0d: gnt=%b, expected %b", cyc, gnt, e.gnt);
            end
            checks++;
            if (qValid !== e.qv || burstLast !== e.bl) begin
                fails++;
                $display("[TB] FAIL rand_pulses cycle %0d: qValid=%b burstLast=%b, expected %b %b",
                         cyc, qValid, burstLast, e.qv, e.bl);
            end
            checks++;
            if (busy !== e.busy) begin
                fails++;
                $display("[TB] FAIL rand_busy cycle %0d: busy=%b, expected %b", cyc, busy, e.busy);
            end
            if (!e.turn) begin
                checks++;
                if (gntId !== e.id) begin
                    fails++;
                    $display("[TB] FAIL rand_id cycle %0d: gntId=%0d, expected %0d", cyc, gntId, e.id);
                end
            end
            // Requests are only withdrawn while their own grant is showing; idle requesters raise at random.
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i] === 1'b1 && $urandom_range(2, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    req[i]   = 1'b1;
                    reqWr[i] = 1'($urandom_range(1, 0));
                end
            end
        end
        req = '0;
    endtask

    initial begin
        $display("[TB] burst_arbiter bench start, turnaround %0s", TatEn ? "enabled" : "disabled");
        test_reset();
        test_single();
        test_turnaround();
        test_drop();
        test_bl2();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/burst_arbiter.md
# burst_arbiter

- Round-robin arbiter that shares the single burst queue/serializer path between `NREQ` command requesters (per-bank queues).
- Per grant it:
  - latches one winner;
  - pulses the queue's `valid` input;
  - holds the grant for the burst duration of BL/2 clock cycles (DDR data);
  - optionally inserts read/write turnaround gaps;
  - re-arbitrates back-to-back without idle cycles when possible.
- Sits between the bank command queues and the queue/burst-counter logic.

## Interface

Parameters:

- `NREQ`, 4, number of requesters; 2..16.
- `BL`, 8, burst length in data beats; even, >=2. Burst occupies BL/2 clock cycles.
- `TAT`, 2, turnaround gap in clock cycles on direction change; >=1. Used only with `BURST_ARB_TAT_EN`.

Ports:

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in NREQ: per-requester request; held until granted.
- `req_wr` in NREQ: per-requester direction; 1 = write, 0 = read. Valid while `req` is high.
- `gnt` out NREQ: one-hot grant, high for the whole burst.
- `gnt_id` out $clog2(NREQ): binary index of current or last winner.
- `q_valid` out 1: one-cycle start pulse to the queue logic, on the first burst cycle.
- `busy` out 1: high in BURST and TURN.
- `burst_last` out 1: high on the final cycle of a burst.

## Operation

- States: IDLE, BURST, TURN (TURN exists only with the macro).
- Registered state: `ptr` (last winner), `last_dir`, `win`/`win_dir` (latched winner), `cnt` ($clog2(BL/2) bits, minimum 1), `tcnt`.
- Arbitration:
  - Round-robin: search starts at `ptr+1` modulo NREQ; first set `req` bit wins.
  - `ptr` updates to the winner when its grant begins.
- IDLE:
  - `req` != 0: latch winner.
  - Go to BURST if direction matches `last_dir` or the macro is off; otherwise go to TURN with `tcnt`=0.
  - `req` == 0: stay.
- BURST:
  - `gnt[win]`=1, `gnt_id`=win, `busy`=1.
  - `cnt` counts 0..BL/2-1; `burst_last`=1 when `cnt`==BL/2-1.
  - On the last cycle, arbitrate among current `req`, excluding the current winner's bit only if it is deasserted.
  - Winner with same direction, or macro off: BURST again next cycle, `cnt`=0, new `q_valid`.
  - Winner with different direction: TURN.
  - No request: IDLE.
  - `last_dir` updates to `win_dir` at burst end.
- TURN:
  - `gnt`=0, `busy`=1.
  - After TAT cycles, go to BURST with the latched winner.
  - `req` changes during TURN are ignored; the winner is committed.
- `req` withdrawn during the requester's own burst: the burst completes.
- No grant is ever given to a requester whose `req` was low at its arbitration cycle.

## Timing

- Reset values:
  - All outputs 0: `gnt`=0, `gnt_id`=0, `q_valid`=0, `busy`=0, `burst_last`=0.
  - State IDLE, `ptr`=NREQ-1 (requester 0 has first priority), `last_dir`=0 (read), `cnt`=0, `tcnt`=0.
- Latency: `req` sampled high in IDLE at edge N → `gnt`/`q_valid`/`busy` high in cycle N+1 (no turnaround).
- `gnt` duration: exactly BL/2 cycles per burst.
- BL=2: `q_valid` and `burst_last` are both high in the single burst cycle.
- Back-to-back same-direction bursts: zero gap; `gnt` switches one-hot directly between requesters.
- Direction change (macro on): exactly TAT cycles with `gnt`=0 between the `burst_last` cycle and the next `q_valid`.
- Reset asserted mid-burst or mid-TURN: all outputs are 0 the next cycle; the burst is abandoned.

## Configuration

- `BURST_ARB_TAT_EN`, defined: TURN state and `TAT` gap are inserted whenever the next winner's direction differs from `last_dir`.
- Undefined:
  - TURN state and `tcnt` are not built.
  - `req_wr` and `last_dir` are ignored for sequencing.
  - All bursts may run back-to-back.

## Test plan

- Reset with `req`=4'b1111 held: `gnt`=0 during reset. First grant to requester 0 one cycle after release, then 1, 2, 3, 0, each for 4 cycles (BL=8), no gaps.
- Single `req[2]` pulse held until grant, all reads: `q_valid` 1 cycle, `gnt`=4'b0100 for 4 cycles, `burst_last` on cycle 4, then IDLE with `busy`=0.
- Macro on, TAT=2, `req[0]` read then `req[1]` write: write `q_valid` arrives exactly 2 idle-grant cycles after the read's `burst_last`. Macro off: 0 cycles.
- `req[1]` dropped mid-burst: burst completes its 4 cycles. `req[1]` low at re-arbitration: no further grant to 1.
- BL=2, `req`=4'b0011: `gnt` alternates 0001/0010 every cycle. `q_valid` and `burst_last` are high every cycle.
- `rst` raised on the 2nd cycle of a burst: the next cycle has `gnt`=0, `busy`=0, and `ptr` reset, so requester 0 wins first after release.
